// File: rtl/key_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_multi
// Brief    : N-channel key debouncer with 2-flop synchronisers, per-channel
//            stability counters, level outputs and press/release strobes.
//            Define KEY_REPEAT_EN to add hold-then-repeat press strobes.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce_multi #(
    parameter int N        = 4,
    parameter int CNT_MAX  = 1000000,
    parameter int HOLD_CYC = 50000000,
    parameter int REP_CYC  = 10000000
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] key_in,
    output logic [N-1:0] key_level,
    output logic [N-1:0] key_press,
    output logic [N-1:0] key_release,
    output logic         key_any
);

    localparam int            CW         = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CW-1:0] C_CNT_LAST = CW'(CNT_MAX - 1);

    if (N < 1 || CNT_MAX < 1 || HOLD_CYC < 1 || REP_CYC < 1) begin : g_bad_param
        $error("key_debounce_multi: N, CNT_MAX, HOLD_CYC and REP_CYC must all be >= 1");
    end

    logic [N-1:0]         s1_q, s2_q;
    logic [N-1:0]         level_q, level_d;
    logic [N-1:0]         press_q, press_d;
    logic [N-1:0]         release_q, release_d;
    logic [N-1:0][CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]         accept_w;

`ifdef KEY_REPEAT_EN
    localparam int            HMAX        = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
    localparam int            HW          = $clog2(HMAX + 1);
    localparam logic [HW-1:0] C_HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [HW-1:0] C_REP_LAST  = HW'(REP_CYC - 1);

    logic [N-1:0][HW-1:0] hold_q, hold_d;
    logic [N-1:0]         rep_q, rep_d;
`endif

    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        cnt_d     = cnt_q;
        accept_w  = '0;
        for (int i = 0; i < N; i++) begin
            if (s2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == C_CNT_LAST) begin
                accept_w[i]  = 1'b1;
                level_d[i]   = s2_q[i];
                cnt_d[i]     = '0;
                press_d[i]   = s2_q[i];
                release_d[i] = ~s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
`ifdef KEY_REPEAT_EN
        hold_d = hold_q;
        rep_d  = rep_q;
        // First target is the hold time, every later target is the repeat period.
        for (int i = 0; i < N; i++) begin
            if (accept_w[i] || !level_q[i]) begin
                hold_d[i] = '0;
                rep_d[i]  = 1'b0;
            end else if (hold_q[i] == (rep_q[i] ? C_REP_LAST : C_HOLD_LAST)) begin
                hold_d[i]  = '0;
                rep_d[i]   = 1'b1;
                press_d[i] = 1'b1;
            end else begin
                hold_d[i] = hold_q[i] + HW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q      <= '0;
            s2_q      <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            cnt_q     <= '0;
        end else begin
            s1_q      <= key_in;
            s2_q      <= s1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_q <= '0;
            rep_q  <= '0;
        end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end
`endif

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_any     = |{press_q, release_q};

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_debounce_multi
// Brief    : Self-checking bench: vector table, directed corner sequences and
//            random key activity against a run-length reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_debounce_multi;

    localparam int N        = 4;
    localparam int CNT_MAX  = 8;
    localparam int HOLD_CYC = 20;
    localparam int REP_CYC  = 6;

    logic         clk  = 1'b0;
    logic         rstn = 1'b0;
    logic [N-1:0] key_in = '0;
    logic [N-1:0] key_level, key_press, key_release;
    logic         key_any;

    key_debounce_multi #(
        .N        (N),
        .CNT_MAX  (CNT_MAX),
        .HOLD_CYC (HOLD_CYC),
        .REP_CYC  (REP_CYC)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_any     (key_any)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: raw keys delayed two edges, then a run length of
    // consecutive disagreeing samples; CNT_MAX of them flips the level.
    logic [N-1:0] m_s1, m_s2, m_lvl, m_press, m_rel;
    int           m_run [N];
    int           m_age [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_rel = '0;
        for (int i = 0; i < N; i++) begin
            m_run[i] = 0;
            m_age[i] = 0;
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] np, nr;
        logic         acc;
        np = '0;
        nr = '0;
        for (int i = 0; i < N; i++) begin
            acc = 1'b0;
            if (m_s2[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == CNT_MAX) begin
                    m_lvl[i] = m_s2[i];
                    if (m_s2[i]) np[i] = 1'b1; else nr[i] = 1'b1;
                    m_run[i] = 0;
                    m_age[i] = 0;
                    acc = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
`ifdef KEY_REPEAT_EN
            if (!acc) begin
                if (m_lvl[i]) begin
                    m_age[i]++;
                    if (m_age[i] >= HOLD_CYC && ((m_age[i] - HOLD_CYC) % REP_CYC) == 0)
                        np[i] = 1'b1;
                end else begin
                    m_age[i] = 0;
                end
            end
`else
            if (acc) m_age[i] = 0;
`endif
        end
        m_press = np;
        m_rel   = nr;
        m_s2    = m_s1;
        m_s1    = key_in;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rstn) model_reset(); else model_edge();
        @(negedge clk);
        check("level",   32'(key_level),   32'(m_lvl));
        check("press",   32'(key_press),   32'(m_press));
        check("release", 32'(key_release), 32'(m_rel));
        check("any",     32'(key_any),     32'(|{m_press, m_rel}));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    typedef struct {
        logic [N-1:0] in;
        int           cyc;
        logic [N-1:0] lvl;
    } vec_t;

    vec_t vecs [12];
    int   npress;

    initial begin
        vecs[0]  = '{4'h0, 12, 4'h0};
        vecs[1]  = '{4'hF, 12, 4'hF};
        vecs[2]  = '{4'h0, 12, 4'h0};
        vecs[3]  = '{4'h5,  7, 4'h0};
        vecs[4]  = '{4'h0, 12, 4'h0};
        vecs[5]  = '{4'hA, 12, 4'hA};
        vecs[6]  = '{4'h2,  7, 4'hA};
        vecs[7]  = '{4'hA, 12, 4'hA};
        vecs[8]  = '{4'h3, 12, 4'h3};
        vecs[9]  = '{4'hC,  5, 4'h3};
        vecs[10] = '{4'h3, 12, 4'h3};
        vecs[11] = '{4'h0, 12, 4'h0};

        // Keys high through reset: press accepted on edge 10 after release.
        model_reset();
        key_in = 4'hF;
        rstn   = 1'b0;
        #1;
        check("rst_level", 32'(key_level), 32'h0);
        check("rst_any",   32'(key_any),   32'h0);
        ticks(2);
        rstn = 1'b1;
        ticks(9);
        check("pwrup_lvl9",  32'(key_level), 32'h0);
        tick();
        check("pwrup_lvl10", 32'(key_level), 32'hF);
        check("pwrup_press", 32'(key_press), 32'hF);
        check("pwrup_any",   32'(key_any),   32'h1);
        tick();
        check("pwrup_press_1cyc", 32'(key_press), 32'h0);

        for (int v = 0; v < 12; v++) begin
            key_in = vecs[v].in;
            ticks(vecs[v].cyc);
            check($sformatf("vec%0d_level", v), 32'(key_level), 32'(vecs[v].lvl));
        end

        // Ch0 toggling every 5 cycles never settles.
        for (int k = 0; k < 12; k++) begin
            key_in[0] = ~key_in[0];
            ticks(5);
        end
        key_in[0] = 1'b0;
        ticks(12);
        check("toggle_level0", 32'(key_level[0]), 32'h0);

        // Ch1 pressed, 7-cycle glitch low, then a real release.
        key_in[1] = 1'b1;
        ticks(12);
        key_in[1] = 1'b0;
        ticks(7);
        key_in[1] = 1'b1;
        ticks(12);
        check("glitch_level1", 32'(key_level[1]), 32'h1);
        key_in[1] = 1'b0;
        ticks(9);
        check("rel_before", 32'(key_release), 32'h0);
        tick();
        check("rel_edge10", 32'(key_release), 32'h2);

        // Ch2 press and ch3 release on the same edge.
        key_in = 4'h8;
        ticks(12);
        key_in = 4'h4;
        ticks(10);
        check("simul_press",   32'(key_press),   32'h4);
        check("simul_release", 32'(key_release), 32'h8);
        check("simul_any",     32'(key_any),     32'h1);
        tick();
        check("simul_any_1cyc", 32'(key_any), 32'h0);

        // Reset during a pending count, then a full re-debounce.
        key_in = 4'hF;
        ticks(7);
        @(negedge clk);
        rstn = 1'b0;
        model_reset();
        #1;
        check("midrst_level", 32'(key_level), 32'h0);
        check("midrst_press", 32'(key_press), 32'h0);
        ticks(3);
        rstn = 1'b1;
        ticks(CNT_MAX + 1);
        check("midrst_lvl_early", 32'(key_level), 32'h0);
        tick();
        check("midrst_lvl_accept", 32'(key_level), 32'hF);

        // Long hold on ch0: repeat strobes only when the feature is built in.
        key_in = 4'h0;
        ticks(14);
        key_in = 4'h1;
        npress = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (key_press[0]) npress++;
        end
`ifdef KEY_REPEAT_EN
        check("hold_press_count", 32'(npress), 32'd5);
`else
        check("hold_press_count", 32'(npress), 32'd1);
`endif
        key_in = 4'h0;
        ticks(14);

        // Random key activity against the model.
        for (int s = 0; s < 300; s++) begin
            key_in = N'($urandom);
            ticks($urandom_range(1, 14));
        end
        key_in = 4'h0;
        ticks(14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
